bpsk_tx_scheduler: RTL

- Front-end controller for the BPSK modulator. Arbitrates round-robin between NUM_REQ sample sources, each supplying 18-bit words.
- Loads the winner's word onto the modulator's parallel input and pulses read_ready for one modulator bit-tick period.
- Waits for the modulator's end-of-frame strobe, then inserts a guard gap before the next frame.
- A watchdog recovers if the end-of-frame strobe never arrives. Sits between the sample sources and the modulator top level.

---
 rtl/bpsk_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/bpsk_tx_scheduler.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bpsk_pkg.sv
// Shared constants, state encoding and elaboration helpers for the BPSK transmit scheduler.
package bpsk_pkg;

  localparam int unsigned BPSK_WORD_W  = 18;
  localparam int unsigned BPSK_BIT_DIV = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWaitDone,
    StGuard
  } sched_state_t;

  // Index width that stays legal for a single-source build.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first requester at or after ptr_i, cyclically.
module rr_arbiter
  import bpsk_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [idx_w(NUM_REQ)-1:0]  ptr_i,
  output logic                       valid_o,
  output logic [idx_w(NUM_REQ)-1:0]  sel_o
);

  localparam int unsigned IdW = idx_w(NUM_REQ);

  logic [IdW-1:0] idx;

  always_comb begin
    valid_o = 1'b0;
    sel_o   = '0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IdW'((32'(ptr_i) + k) % NUM_REQ);
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        sel_o   = idx;
      end
    end
  end

endmodule

// File: rtl/bpsk_tx_scheduler.sv
// Front-end scheduler for the BPSK modulator: round-robin source arbitration, load handshake,
// end-of-frame wait with watchdog, and inter-frame guard gap.
module bpsk_tx_scheduler
  import bpsk_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned WORD_W     = BPSK_WORD_W,
  parameter int unsigned BIT_DIV    = BPSK_BIT_DIV,
  parameter int unsigned GUARD_BITS = 2,
  parameter int unsigned TIMEOUT    = 176
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*WORD_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          grant,
  output logic [WORD_W-1:0]           mod_data,
  output logic                        read_ready,
  input  logic                        mod_done,
  output logic                        busy,
  output logic [idx_w(NUM_REQ)-1:0]   active_id,
  output logic                        err_timeout,
  output logic [15:0]                 words_sent
);

  localparam int unsigned IdW      = idx_w(NUM_REQ);
  localparam int unsigned GuardCyc = GUARD_BITS * BIT_DIV;
  localparam int unsigned CntMax   = max3(TIMEOUT, GuardCyc, BIT_DIV);
  localparam int unsigned CntW     = $clog2(CntMax + 1);

  sched_state_t        state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [WORD_W-1:0]   mod_data_q, mod_data_d;
  logic                read_ready_q, read_ready_d;
  logic                busy_q, busy_d;
  logic [IdW-1:0]      active_id_q, active_id_d;
  logic                err_timeout_q, err_timeout_d;
  logic [15:0]         words_sent_q, words_sent_d;

  logic                arb_valid;
  logic [IdW-1:0]      arb_sel;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (arb_valid),
    .sel_o   (arb_sel)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    grant_d       = '0;
    mod_data_d    = mod_data_q;
    read_ready_d  = read_ready_q;
    active_id_d   = active_id_q;
    err_timeout_d = err_timeout_q;
    words_sent_d  = words_sent_q;

    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_sel == IdW'(i)) begin
              grant_d[i] = 1'b1;
              mod_data_d = req_data[i*WORD_W +: WORD_W];
            end
          end
          active_id_d = arb_sel;
          ptr_d       = (arb_sel == IdW'(NUM_REQ - 1)) ? '0 : arb_sel + IdW'(1);
          state_d     = StLoad;
          cnt_d       = '0;
        end
      end
      StLoad: begin
        // read_ready rises one cycle after grant and is held for BIT_DIV cycles.
        if (cnt_q == CntW'(BIT_DIV)) begin
          read_ready_d = 1'b0;
          cnt_d        = '0;
          state_d      = StWaitDone;
        end else begin
          read_ready_d = 1'b1;
          cnt_d        = cnt_q + CntW'(1);
        end
      end
      StWaitDone: begin
        if (mod_done) begin
          words_sent_d = words_sent_q + 16'd1;
          cnt_d        = '0;
          state_d      = StGuard;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          cnt_d         = '0;
          state_d       = StGuard;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGuard: begin
        if (cnt_q == CntW'(GuardCyc - 1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      ptr_q         <= '0;
      grant_q       <= '0;
      mod_data_q    <= '0;
      read_ready_q  <= 1'b0;
      busy_q        <= 1'b0;
      active_id_q   <= '0;
      err_timeout_q <= 1'b0;
      words_sent_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      mod_data_q    <= mod_data_d;
      read_ready_q  <= read_ready_d;
      busy_q        <= busy_d;
      active_id_q   <= active_id_d;
      err_timeout_q <= err_timeout_d;
      words_sent_q  <= words_sent_d;
    end
  end

  assign grant       = grant_q;
  assign mod_data    = mod_data_q;
  assign read_ready  = read_ready_q;
  assign busy        = busy_q;
  assign active_id   = active_id_q;
  assign err_timeout = err_timeout_q;
  assign words_sent  = words_sent_q;

endmodule
